sram_like_responder: RTL and testbench

Responder (slave) end of the team's SRAM-like req/addr_ok/data_ok bus, the same protocol the CPU core drives on its instruction and data ports. It accepts one request per cycle, holds a word-addressed memory, and returns responses strictly in order with programmable latency. Two stall inputs inject backpressure. It is used as the memory model behind the core in simulation and as the on-chip scratch RAM.

---
 rtl/sram_like_pkg.sv | 29 ++
 rtl/sram_like_responder_resp_fifo.sv | 57 +++++
 rtl/sram_like_responder.sv | 62 ++++++
 tb/tb_sram_like_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared field widths, response-queue entry type and byte-merge helper for the
// SRAM-like req/addr_ok/data_ok bus.
package sram_like_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
  } resp_entry_t;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// In-order response queue; every slot's latency counter counts down to zero and
// the head may leave once its counter has expired.
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_ready,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  resp_entry_t       slots [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign head_ready = ~empty & (slots[rd_ptr].cnt == '0);
  assign head_data  = slots[rd_ptr].data;

  // Idle slots also count down; harmless since a push overwrites the whole entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slots[i].cnt != '0) slots[i].cnt <= slots[i].cnt - 8'd1;
      end
      if (push) begin
        slots[wr_ptr] <= '{cnt: push_cnt, data: push_data};
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus responder: word memory with byte strobes, fixed-latency in-order
// responses and addr/data backpressure inputs. Memory is never reset.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [SIZE_W-1:0] size,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  input  logic              addr_stall,
  input  logic              data_stall
);

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              full;
  logic              empty;
  logic              head_ready;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] push_data;
  logic              unused_bits;

  assign idx       = addr[MEM_AW+1:2];
  assign addr_ok   = resetn & ~addr_stall & ~full;
  assign accept    = req & addr_ok;
  // Read word is sampled at the accept edge, so it reflects all earlier writes.
  assign push_data = wr ? '0 : mem[idx];
  assign data_ok   = ~empty & head_ready & ~data_stall;
  assign rdata     = data_ok ? head_data : '0;

  assign unused_bits = ^{size, addr[ADDR_W-1:MEM_AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
  end

  resp_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_cnt   (CNT_W'(LATENCY - 1)),
    .push_data  (push_data),
    .pop        (data_ok),
    .head_ready (head_ready),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: reset, latency/strobe vector table, full/backpressure,
// mid-operation reset, and a LATENCY=1 streaming run with a scoreboard.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr, addr_stall, data_stall;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        s_req, s_wr, s_addr_stall, s_data_stall;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_responder u_dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .addr_stall(addr_stall), .data_stall(data_stall)
  );

  sram_like_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(s_req), .wr(s_wr), .size(size), .wstrb(s_wstrb),
    .addr(s_addr), .wdata(s_wdata), .addr_ok(s_addr_ok), .data_ok(s_data_ok), .rdata(s_rdata),
    .addr_stall(s_addr_stall), .data_stall(s_data_stall)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dstall;
    logic        astall;
    logic        exp_aok;
    logic        exp_dok;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [17];
  logic [33:0] full_exp [6];
  logic [31:0] q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; wstrb = s; addr = a; wdata = d;
  endtask

  function automatic logic [31:0] wval(input int i);
    return 32'h1000_0000 | 32'(i);
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'h2, 32'h20, 32'h0000AA00, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h20, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h1122AA44};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

    // {addr_ok, data_ok, rdata} while the full queue drains
    full_exp[0] = {1'b0, 1'b1, wval(0)};
    full_exp[1] = {1'b1, 1'b1, wval(1)};
    full_exp[2] = {1'b1, 1'b1, wval(2)};
    full_exp[3] = {1'b1, 1'b1, wval(3)};
    full_exp[4] = {1'b1, 1'b1, wval(4)};
    full_exp[5] = {1'b1, 1'b0, 32'h0};

    size = 2'b10;
    resetn = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    addr_stall = 1'b0; data_stall = 1'b0;
    s_req = 1'b0; s_wr = 1'b0; s_wstrb = 4'h0; s_addr = 32'h0; s_wdata = 32'h0;
    s_addr_stall = 1'b0; s_data_stall = 1'b0;

    // reset held with req high
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {30'd0, addr_ok, data_ok, rdata}, 64'd0);
    end
    next_cycle();
    resetn = 1'b1;

    // vector table, row 0 is the first cycle after release
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].req, vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
      data_stall = vecs[i].dstall;
      addr_stall = vecs[i].astall;
      @(negedge clk);
      check($sformatf("vec%0d", i), {30'd0, addr_ok, data_ok, rdata},
            {30'd0, vecs[i].exp_aok, vecs[i].exp_dok, vecs[i].exp_rdata});
      next_cycle();
    end
    addr_stall = 1'b0; data_stall = 1'b0;

    // full / backpressure
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 4'hF, 32'(4 * i), wval(i));
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (4) next_cycle();
    data_stall = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 4'h0, (c < 4) ? 32'(4 * c) : 32'h10, 32'h0);
      @(negedge clk);
      check($sformatf("full_fill%0d", c), {62'd0, addr_ok, data_ok}, {62'd0, (c < 4), 1'b0});
      next_cycle();
    end
    data_stall = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check($sformatf("full_drain%0d", c), {30'd0, addr_ok, data_ok, rdata}, {30'd0, full_exp[c]});
      next_cycle();
    end

    // reset with three reads outstanding
    data_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 4'h0, 32'(4 * c), 32'h0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    data_stall = 1'b0;
    resetn = 1'b0;
    #1;
    check("midreset_outputs", {30'd0, addr_ok, data_ok, rdata}, 64'd0);
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("release_addr_ok", {63'd0, addr_ok}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("discarded%0d", c), {63'd0, data_ok}, 64'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("readback0", {31'd0, data_ok, rdata}, {31'd0, 1'b1, wval(0)});
    next_cycle();
    @(negedge clk);
    check("readback1", {31'd0, data_ok, rdata}, {31'd0, 1'b1, wval(1)});
    next_cycle();

    // streaming on the LATENCY=1 instance
    for (int i = 0; i < 16; i++) begin
      s_req = 1'b1; s_wr = 1'b1; s_wstrb = 4'hF;
      s_addr = 32'(4 * i); s_wdata = 32'hC000_0000 | 32'(i);
      next_cycle();
    end
    s_req = 1'b0; s_wr = 1'b0;
    repeat (3) next_cycle();
    begin
      int n_acc;
      int n_resp;
      n_acc = 0;
      n_resp = 0;
      for (int c = 0; c < 230; c++) begin
        s_req        = (c < 200);
        s_addr       = 32'(4 * (c % 16));
        s_addr_stall = ($urandom_range(0, 3) == 0);
        s_data_stall = ($urandom_range(0, 4) == 0);
        @(negedge clk);
        check("stream_addr_ok", {63'd0, s_addr_ok},
              {63'd0, (~s_addr_stall & (q.size() < 4))});
        check("stream_data_ok", {63'd0, s_data_ok},
              {63'd0, ((q.size() > 0) & ~s_data_stall)});
        if (s_data_ok && q.size() > 0) begin
          n_resp++;
          check("stream_rdata", {32'd0, s_rdata}, {32'd0, q.pop_front()});
        end
        if (s_req && s_addr_ok) begin
          n_acc++;
          q.push_back(32'hC000_0000 | 32'(c % 16));
        end
        next_cycle();
      end
      check("stream_resp_count", 64'(n_resp), 64'(n_acc));
      check("stream_queue_empty", 64'(q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
